// File: rtl/operand_tf_pkg.sv
// operand_tf_pkg: operand bundles exchanged with operand_transformer, plus arbiter defaults.
package operand_tf_pkg;
    localparam int OPT_NUM_REQ = 4;
    localparam int OPT_TAG_DEPTH = 4;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  scale;
        logic        mode;
    } operand_input_t;
    typedef struct packed {
        logic [35:0] data;
    } operand_output_t;
endpackage

// File: rtl/operand_tf_arbiter_if.sv
// operand_tf_arb_if: requester, transformer and response handshakes of the arbiter.
interface operand_tf_arb_if import operand_tf_pkg::*; #(parameter int NUM_REQ = OPT_NUM_REQ);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    operand_input_t [NUM_REQ-1:0] req_data;
    logic tf_valid_in;
    logic tf_ready_in;
    operand_input_t tf_data_in;
    logic tf_valid_out;
    logic tf_ready_out;
    operand_output_t tf_data_out;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [NUM_REQ-1:0] rsp_ready;
    operand_output_t rsp_data;
    modport master (
        input  req_valid, req_data, tf_ready_in, tf_valid_out, tf_data_out, rsp_ready,
        output req_ready, tf_valid_in, tf_data_in, tf_ready_out, rsp_valid, rsp_data
    );
    modport slave (
        output req_valid, req_data, tf_ready_in, tf_valid_out, tf_data_out, rsp_ready,
        input  req_ready, tf_valid_in, tf_data_in, tf_ready_out, rsp_valid, rsp_data
    );
endinterface

// File: rtl/operand_tf_arbiter_fifo.sv
// opt_tag_fifo: synchronous FIFO with occupancy count; push when full and pop when empty are ignored.
module opt_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic [WIDTH-1:0] wdata,
    input  logic pop,
    output logic [WIDTH-1:0] rdata,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/operand_tf_arbiter.sv
// operand_tf_arbiter: round-robin sharing of one operand_transformer; results return in order
// to the requester recorded in the tag FIFO. Both paths are purely combinational.
module operand_tf_arbiter import operand_tf_pkg::*; #(
    parameter int NUM_REQ = OPT_NUM_REQ,
    parameter int TAG_DEPTH = OPT_TAG_DEPTH
) (
    input  logic clk,
    input  logic rst,
    operand_tf_arb_if.master bus,
    output logic [$clog2(TAG_DEPTH):0] inflight,
    output logic busy,
    output logic err_orphan
);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);
    logic [PW-1:0] rr_ptr, g, off, head;
    logic [PW:0] sum;
    logic [2*NUM_REQ-1:0] rot;
    logic full, empty, accept, pop;
    // doubled vector shifted by rr_ptr turns the rotation into a plain lowest-bit search
    always_comb begin
        rot = {bus.req_valid, bus.req_valid} >> rr_ptr;
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? PW'(i) : off;
        sum = {1'b0, rr_ptr} + {1'b0, off};
        g = PW'(sum >= NR ? sum - NR : sum);
    end
    assign bus.tf_valid_in = |bus.req_valid && !full;
    assign accept = bus.tf_valid_in && bus.tf_ready_in && !rst;
    assign bus.req_ready = accept ? NUM_REQ'(1) << g : '0;
    assign bus.tf_data_in = bus.req_data[g];
    assign bus.rsp_valid = (bus.tf_valid_out && !empty) ? NUM_REQ'(1) << head : '0;
    assign bus.tf_ready_out = !empty && bus.rsp_ready[head] && !rst;
    assign bus.rsp_data = bus.tf_data_out;
    assign pop = bus.tf_valid_out && bus.tf_ready_out;
    assign busy = inflight != '0;
    opt_tag_fifo #(.WIDTH(PW), .DEPTH(TAG_DEPTH)) u_tags (
        .clk(clk),
        .rst(rst),
        .push(accept),
        .wdata(g),
        .pop(pop),
        .rdata(head),
        .full(full),
        .empty(empty),
        .count(inflight)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (accept) rr_ptr <= g == PW'(NUM_REQ - 1) ? '0 : g + 1'b1;
            if (bus.tf_valid_out && empty) err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_operand_tf_arbiter.sv
// tb_operand_tf_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_operand_tf_arbiter;
    import operand_tf_pkg::*;
    localparam int N = 4;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] inflight;
    logic busy, err_orphan;
    operand_tf_arb_if #(.NUM_REQ(N)) bus ();
    operand_tf_arbiter #(.NUM_REQ(N), .TAG_DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .inflight(inflight),
        .busy(busy),
        .err_orphan(err_orphan)
    );
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [N-1:0] rv, rr_in, obs_ready, obs_rsp;
    logic tin, tvo, do_rst, quiet, obs_tro;
    operand_input_t rd [N];
    operand_output_t orphan_data;
    int rr;
    bit orph;
    int tagq [$];
    operand_output_t expq [$];
    operand_input_t tfq [$];
    int cnt [N];
    int n;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic operand_output_t xf(operand_input_t x);
        operand_output_t o;
        o.data = 36'(x.data) * 36'd3 + 36'(x.scale) + 36'(x.mode);
        return o;
    endfunction

    function automatic operand_input_t rand_req();
        operand_input_t x;
        x.data = $urandom;
        x.scale = 2'($urandom);
        x.mode = 1'($urandom);
        return x;
    endfunction

    // drive one cycle at the falling edge, compare against the model, then advance both
    task automatic step();
        int g;
        bit any, en_in, acc, ready_out;
        logic [N-1:0] exp_rv;
        rst = do_rst;
        bus.req_valid = rv;
        bus.rsp_ready = rr_in;
        bus.tf_ready_in = tin;
        bus.tf_valid_out = tvo;
        for (int i = 0; i < N; i++) bus.req_data[i] = rd[i];
        if (tfq.size() > 0) bus.tf_data_out = xf(tfq[0]);
        else bus.tf_data_out = orphan_data;
        #1;
        any = |rv;
        g = rr;
        for (int k = N - 1; k >= 0; k--) if (rv[(rr + k) % N]) g = (rr + k) % N;
        en_in = any && tagq.size() < D;
        acc = en_in && tin && !do_rst;
        ready_out = tagq.size() > 0 && rr_in[tagq[0]] && !do_rst;
        exp_rv = (tvo && tagq.size() > 0) ? N'(1) << tagq[0] : '0;
        obs_ready = bus.req_ready;
        obs_rsp = bus.rsp_valid;
        obs_tro = bus.tf_ready_out;
        if (!quiet) begin
            check("tf_valid_in", 64'(bus.tf_valid_in), 64'(en_in));
            check("req_ready", 64'(bus.req_ready), acc ? 64'(1) << g : 64'(0));
            if (any) check("tf_data_in", 64'(bus.tf_data_in), 64'(rd[g]));
            check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
            check("tf_ready_out", 64'(bus.tf_ready_out), 64'(ready_out));
            if (exp_rv != '0) check("rsp_data", 64'(bus.rsp_data), 64'(expq[0]));
            check("inflight", 64'(inflight), 64'(tagq.size()));
            check("busy", 64'(busy), 64'(tagq.size() != 0));
            check("err_orphan", 64'(err_orphan), 64'(orph));
        end
        if (do_rst) begin
            tagq.delete();
            expq.delete();
            tfq.delete();
            rr = 0;
            orph = 0;
            tvo = 0;
        end else begin
            if (tvo && tagq.size() == 0) orph = 1;
            if (tvo && ready_out) begin
                void'(tagq.pop_front());
                void'(expq.pop_front());
                void'(tfq.pop_front());
                tvo = 0;
            end
            if (acc) begin
                tagq.push_back(g);
                expq.push_back(xf(rd[g]));
                tfq.push_back(bus.tf_data_in);
                rr = (g + 1) % N;
                rv[g] = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        do_rst = 1'b1;
        step();
        do_rst = 1'b0;
    endtask

    task automatic drain();
        rv = '0;
        rr_in = '1;
        tin = 1'b1;
        for (int c = 0; c < 50 && tagq.size() > 0; c++) begin
            if (!tvo) tvo = tfq.size() > 0;
            step();
        end
        check("drain_inflight", 64'(inflight), 64'(0));
    endtask

    initial begin
        rv = '0;
        rr_in = '0;
        tin = 1'b0;
        tvo = 1'b0;
        do_rst = 1'b1;
        quiet = 1'b1;
        orphan_data = '0;
        rr = 0;
        orph = 0;
        for (int i = 0; i < N; i++) rd[i] = rand_req();
        step();
        quiet = 1'b0;
        reset_dut();
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_orphan", 64'(err_orphan), 64'(0));

        rv = 4'b0100;
        tin = 1'b1;
        step();
        check("single_ready", 64'(obs_ready), 64'h4);
        check("single_inflight", 64'(inflight), 64'd1);
        tvo = 1'b1;
        rr_in = '1;
        step();
        check("single_rsp", 64'(obs_rsp), 64'h4);
        check("single_busy", 64'(busy), 64'(0));
        rv = 4'b1001;
        step();
        check("rr_after_single", 64'(obs_ready), 64'h8);
        drain();

        reset_dut();
        n = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 200 && n < 16; c++) begin
            rv = '1;
            rr_in = '1;
            tin = 1'b1;
            if (!tvo) tvo = tfq.size() > 0;
            step();
            if (obs_ready != '0) begin
                check("grant_order", 64'(obs_ready), 64'(1) << (n % N));
                for (int i = 0; i < N; i++) if (obs_ready[i]) cnt[i]++;
                n++;
            end
        end
        for (int i = 0; i < N; i++) check("fair_share", 64'(cnt[i]), 64'd4);
        drain();

        reset_dut();
        rr_in = '0;
        tin = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rv = '1;
            step();
        end
        check("full_inflight", 64'(inflight), 64'd4);
        check("full_valid_in", 64'(bus.tf_valid_in), 64'(0));
        rv = '1;
        tvo = 1'b1;
        rr_in = '1;
        step();
        check("pop_no_push", 64'(obs_ready), 64'(0));
        rv = '1;
        step();
        check("push_after_pop", 64'(obs_ready), 64'h1);
        drain();

        reset_dut();
        rv = 4'b1010;
        tin = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("tf_stall_ready", 64'(obs_ready), 64'(0));
        end
        tin = 1'b1;
        step();
        check("release_grant", 64'(obs_ready), 64'h2);
        drain();

        reset_dut();
        rv = '0;
        orphan_data = xf(rand_req());
        tvo = 1'b1;
        step();
        check("orphan_ready_out", 64'(obs_tro), 64'(0));
        check("orphan_set", 64'(err_orphan), 64'(1));
        tvo = 1'b0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) if (!rv[i] && $urandom_range(0, 2) == 0) begin
                rv[i] = 1'b1;
                rd[i] = rand_req();
            end
            tin = $urandom_range(0, 3) != 0;
            rr_in = N'($urandom);
            if (!tvo) tvo = tfq.size() > 0 && $urandom_range(0, 2) != 0;
            step();
        end
        check("orphan_sticky", 64'(err_orphan), 64'(1));
        reset_dut();
        check("orphan_clear", 64'(err_orphan), 64'(0));

        tin = 1'b1;
        rr_in = '0;
        tvo = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rv = '1;
            step();
        end
        check("pre_rst_inflight", 64'(inflight), 64'd3);
        rv = '0;
        reset_dut();
        check("rst_inflight", 64'(inflight), 64'(0));
        tvo = 1'b1;
        rr_in = '1;
        rv = '1;
        step();
        check("rst_rsp_valid", 64'(obs_rsp), 64'(0));
        check("rst_rr_ptr", 64'(obs_ready), 64'h1);
        tvo = 1'b0;
        reset_dut();

        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) if (!rv[i] && $urandom_range(0, 2) == 0) begin
                rv[i] = 1'b1;
                rd[i] = rand_req();
            end
            tin = $urandom_range(0, 3) != 0;
            rr_in = N'($urandom);
            if (!tvo) tvo = tfq.size() > 0 && $urandom_range(0, 2) != 0;
            do_rst = $urandom_range(0, 499) == 0;
            step();
            do_rst = 1'b0;
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operand_tf_arbiter.md
# operand_tf_arbiter

- Shares one `operand_transformer` instance between `NUM_REQ` requesters.
- Requester selection is round-robin; each accepted request's requester index is recorded in an in-order tag FIFO.
- Each transformer result is routed back to the requester at the FIFO head.
- Sits between the operand-collector ports and the transformer; adds no cycle of latency on either the request path or the response path.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `TAG_DEPTH`, 4: maximum transformer transactions in flight (tag FIFO entries), power of two.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NUM_REQ: per-requester request valid.
- `req_ready` output NUM_REQ: per-requester accept; at most one bit set per cycle.
- `req_data` input NUM_REQ × operand_input_t: per-requester operand bundle.
- `tf_valid_in` output 1: valid to transformer input.
- `tf_ready_in` input 1: ready from transformer input.
- `tf_data_in` output operand_input_t: selected request bundle.
- `tf_valid_out` input 1: transformer result valid.
- `tf_ready_out` output 1: ready to transformer output.
- `tf_data_out` input operand_output_t: transformer result.
- `rsp_valid` output NUM_REQ: one-hot response valid.
- `rsp_ready` input NUM_REQ: per-requester response ready.
- `rsp_data` output operand_output_t: `tf_data_out` broadcast to all requesters, unregistered.
- `inflight` output TAGW+1: tag FIFO occupancy, where TAGW = $clog2(TAG_DEPTH).
- `busy` output 1: `inflight != 0`.
- `err_orphan` output 1: sticky flag; set when a result arrives with no outstanding tag.

## Operation
Request arbitration:
- `rr_ptr` (width $clog2(NUM_REQ)) is the highest-priority index.
- The grant `g` is the first index with `req_valid` set, scanning `rr_ptr`, `rr_ptr+1`, … modulo NUM_REQ.
- `tf_valid_in = |req_valid && !full`. It does not depend on `tf_ready_in`.
- `tf_data_in = req_data[g]`. When no request is valid, `tf_data_in` is `req_data[rr_ptr]` (don't-care).
- `req_ready[g] = tf_valid_in && tf_ready_in`; all other `req_ready` bits are 0.
- On an accept:
  - push `g` into the tag FIFO;
  - set `rr_ptr <= (g+1) mod NUM_REQ`.
- `rr_ptr` is unchanged in any cycle without an accept.
- A requester must hold `req_valid` and `req_data` stable until accepted. The grant may move to a different requester while no accept occurs.

Response routing:
- `head` is the tag at the FIFO read pointer.
- `rsp_valid[head] = tf_valid_out && !empty`; all other bits are 0.
- `tf_ready_out = !empty && rsp_ready[head]`.
- On `tf_valid_out && tf_ready_out`, pop the FIFO.
- If `tf_valid_out && empty`:
  - `tf_ready_out` stays 0;
  - set `err_orphan`, which is cleared only by `rst`;
  - nothing is routed.

FIFO and counters:
- Pointers are TAGW bits and wrap naturally. `inflight` is a separate counter.
- `full = (inflight == TAG_DEPTH)`; `empty = (inflight == 0)`.
- Simultaneous push and pop: `inflight` is unchanged; the write and read pointers both advance.
- When full, push is blocked even if a pop occurs in the same cycle (`full` is computed from registered occupancy). This keeps ready paths free of response-side logic.
- Empty with push: the pushed tag is not poppable until the next cycle. The transformer latency is ≥1, so this is not a restriction.

## Timing
- Request path: combinational. Requester to transformer accept happens in the same cycle.
- Response path: combinational. Transformer result to requester happens in the same cycle.
- Registered state: `rr_ptr`, FIFO storage and pointers, `inflight`, `err_orphan`.
- Reset values (applied at the rising edge with `rst`=1):
  - `rr_ptr` = 0; FIFO empty; `inflight` = 0; `err_orphan` = 0.
  - Resulting outputs: `busy` = 0, `tf_valid_in` = `|req_valid`, all `rsp_valid` = 0, `tf_ready_out` = 0.
- Reset mid-operation:
  - Outstanding tags are discarded.
  - The transformer must be reset in the same cycle by the integration.
  - Results that arrive afterwards set `err_orphan`.
- Outputs while `rst` is high:
  - `req_ready` is forced to 0;
  - `tf_ready_out` is forced to 0;
  - no push or pop occurs.

## Structure
- `operand_tf_pkg` already holds `operand_input_t` and `operand_output_t`.
- Add to the package:
  - `OPT_NUM_REQ`, the default requester count;
  - `OPT_TAG_DEPTH`, the default tag depth.
- Sub-module `opt_tag_fifo`: a synchronous FIFO with parameters `WIDTH` and `DEPTH`, providing push/pop, full/empty and count. It is reusable elsewhere in the codebase.
- The round-robin scan lives in the top level as a double-width priority encode over `{req_valid, req_valid}` rotated by `rr_ptr`.

## Test plan
- Reset, then single request: `req_valid`=4'b0100 with `tf_ready_in`=1 → `req_ready`=4'b0100 in the same cycle, `inflight`=1, `rr_ptr`=3. The result returns with `rsp_valid`=4'b0100 and flattened elements matching the transformer's calc_expected (Elems 1,3,7…255; scales 0–3, mode 0); `busy` then falls to 0.
- All four requesters valid continuously, `rsp_ready` all 1 → grant order 0,1,2,3,0,…; each requester gets exactly 4 of 16 accepts; responses are in order with correct one-hot routing.
- Transformer output stalled (`rsp_ready`=0) → after 4 accepts `inflight`=4 and `tf_valid_in`=0. In a cycle with one pop and a pending request, no push occurs; the push happens the next cycle.
- `tf_ready_in`=0 for 5 cycles with `req_valid`=4'b1010 → no `req_ready`, `rr_ptr` unchanged; on release, requester 1 is granted first (from `rr_ptr`=0).
- `tf_valid_out` forced high with FIFO empty → `tf_ready_out`=0, `err_orphan`=1, and it stays 1 until `rst`.
- `rst` asserted with 3 in flight → next cycle `inflight`=0, `rr_ptr`=0, all `rsp_valid`=0.
